instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch unit that acts as the requesting end of the instruction memory interface: it holds the fetch PC, drives the 64-bit address into the combinational instruction memory, waits a programmable settling time, and captures the 32-bit instruction word. Captured words are buffered with their PC in a small FIFO and handed to decode over a valid/ready handshake. A redirect port loads a new PC for branches and CBZ, flushing all buffered wrong-path instructions.

## Interface
- WAIT_CYCLES, 2, clock edges the address is held before data is sampled; covers the memory T_rd of 20 ns. Legal range 0..15.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.
- RESET_PC, 64'h0, fetch PC loaded on reset.
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- IMemAddress  out  64  address to instruction memory; always equals FetchPC.
- IMemData  in  32  instruction word from memory.
- InstrValid  out  1  FIFO head holds a valid instruction.
- InstrReady  in  1  decode accepts the head this cycle.
- Instr  out  32  head instruction word; 0 when empty.
- InstrPC  out  64  PC of the head instruction; 0 when empty.
- Redirect  in  1  one-cycle request to restart fetch at RedirectPC.
- RedirectPC  in  64  new fetch PC; bits [1:0] are forced to 0.

## Operation
- Registers: FetchPC (64 bits), wait counter cnt (4 bits), state {WAIT, HOLD}, and a FIFO of {PC, word} entries with read and write pointers and a count.
- In WAIT:
  - If cnt < WAIT_CYCLES, cnt increments.
  - If cnt == WAIT_CYCLES and a push is allowed, {FetchPC, IMemData} is pushed, FetchPC advances by 4 (64-bit wrap, no overflow flag), and cnt returns to 0.
  - If cnt == WAIT_CYCLES and no push is allowed, the state goes to HOLD.
- In HOLD: the address is held and the data stays stable. Once a push is allowed, the word is pushed, FetchPC advances by 4, cnt returns to 0, and the state returns to WAIT.
- Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Pop occurs when InstrValid && InstrReady. The pop and the push can happen together; count is unchanged and order is preserved.
- Redirect has priority over everything else that cycle:
  - FIFO is emptied.
  - Any push or pop that cycle is discarded.
  - FetchPC is set to {RedirectPC[63:2], 2'b00}, cnt to 0, and the state to WAIT.
- IMemData is not checked; X words from unmapped addresses are buffered as-is, and decode is responsible for them.

## Timing
- Reset values:
  - FetchPC = RESET_PC, so IMemAddress = RESET_PC during and immediately after reset.
  - cnt = 0, state = WAIT, FIFO empty.
  - InstrValid = 0, Instr = 0, InstrPC = 0.
- Reset asserted mid-fetch or mid-HOLD:
  - All buffered entries are lost.
  - Outputs go to their reset values asynchronously, without waiting for CLK.
- Fetch latency: WAIT_CYCLES+1 rising edges from the first edge after a new FetchPC until the push edge. InstrValid goes high in the cycle after the push edge.
- Throughput: one word per WAIT_CYCLES+1 cycles while the FIFO is not full. With WAIT_CYCLES=0, one word per cycle.
- Outputs are registered FIFO-head values; there is no combinational path from IMemData to Instr.
- Redirect latency: IMemAddress shows the new PC in the cycle after the Redirect edge. InstrValid is 0 from that cycle until the first new-path push.
- Decode rules:
  - Decode must not rely on InstrValid dropping without a pop, except on a redirect.
  - Instr and InstrPC stay stable while InstrValid=1 and InstrReady=0.

## Test plan
- Reset, WAIT_CYCLES=2, memory holds 910003E1@0, 910007E2@4, 910003E3@8, InstrReady=1 → IMemAddress 0, 4, 8, each held 3 cycles; Instr/InstrPC sequence is 910003E1/0, 910007E2/4, 910003E3/8; first InstrValid in cycle 4 after reset release.
- Backpressure: InstrReady=0 for 20 cycles → 2 entries buffered, state HOLD with IMemAddress=8, no word lost or duplicated; after InstrReady=1, outputs resume in order 0, 4, 8.
- Full FIFO with simultaneous pop and push → count stays 2, PC order remains strictly +4.
- Redirect to 64'h00e (pulse with 2 words buffered) → InstrValid=0 next cycle, IMemAddress=64'h00c, next delivered Instr 8B020021 with InstrPC 00c.
- Redirect asserted in the same cycle as a push edge → pushed word discarded, FIFO empty, FetchPC = redirect target.
- Reset asserted mid-HOLD → outputs zero immediately, IMemAddress=RESET_PC; fetch restarts cleanly and refetches 910003E1.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch PC, settle-wait memory read, {PC, word} buffer toward decode
module instruction_fetch #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          FIFO_DEPTH  = 2,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] IMemAddress,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC
);

    localparam int             PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]     WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {S_WAIT, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [63:0]      pc_mem   [FIFO_DEPTH];
    logic [31:0]      word_mem [FIFO_DEPTH];

    logic             pop_req;
    logic             push_ok;
    logic             push;
    logic             pop;

    assign IMemAddress = fetch_pc_q;
    assign InstrValid  = (count_q != '0);
    assign Instr       = InstrValid ? word_mem[rd_ptr_q] : 32'h0;
    assign InstrPC     = InstrValid ? pc_mem[rd_ptr_q]   : 64'h0;

    // A full buffer still accepts a push when its head leaves in the same cycle.
    assign pop_req = InstrValid && InstrReady;
    assign push_ok = (count_q != DEPTH_C) || pop_req;
    assign pop     = pop_req && !Redirect;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        if (Redirect) begin
            fetch_pc_d = RedirectPC & ~64'h3;
            cnt_d      = 4'd0;
            state_d    = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q < WAIT_LAST) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (push_ok) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 64'd4;
                        cnt_d      = 4'd0;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (push_ok) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 64'd4;
                        cnt_d      = 4'd0;
                        state_d    = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
            else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_WAIT;
            cnt_q      <= 4'd0;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: count_q gates every read of it.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            word_mem[wr_ptr_q] <= IMemData;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vectors for instruction_fetch with hand-computed expectations
module tb_instruction_fetch;

    logic        CLK;
    logic        Reset;
    logic [63:0] IMemAddress;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        Redirect;
    logic [63:0] RedirectPC;

    int n_cmp;
    int n_bad;

    instruction_fetch #(
        .WAIT_CYCLES(2),
        .FIFO_DEPTH (2),
        .RESET_PC   (64'h0)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .IMemAddress(IMemAddress),
        .IMemData   (IMemData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h0:   imem = 32'h910003E1;
            64'h4:   imem = 32'h910007E2;
            64'h8:   imem = 32'h910003E3;
            64'hc:   imem = 32'h8B020021;
            default: imem = {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign IMemData = imem(IMemAddress);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc, input logic [31:0] w);
        check_val({tag, "_valid"}, 64'(InstrValid), 64'd1);
        check_val({tag, "_instr"}, 64'(Instr), 64'(w));
        check_val({tag, "_pc"}, InstrPC, pc);
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_valid"}, 64'(InstrValid), 64'd0);
        check_val({tag, "_instr"}, 64'(Instr), 64'd0);
        check_val({tag, "_pc"}, InstrPC, 64'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        Reset      = 1'b1;
        InstrReady = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 64'h0;

        // Reset state and in-order streaming with decode always ready
        #2;
        check_empty("rst");
        check_val("rst_addr", IMemAddress, 64'h0);
        tick(2);
        Reset = 1'b0;
        tick(2);
        check_val("lat_valid_c2", 64'(InstrValid), 64'd0);
        check_val("lat_addr_c2", IMemAddress, 64'h0);
        tick(1);
        check_head("seq0", 64'h0, 32'h910003E1);
        check_val("seq0_addr", IMemAddress, 64'h4);
        tick(1);
        check_val("seq_pop_valid", 64'(InstrValid), 64'd0);
        tick(2);
        check_head("seq1", 64'h4, 32'h910007E2);
        check_val("seq1_addr", IMemAddress, 64'h8);
        tick(3);
        check_head("seq2", 64'h8, 32'h910003E3);
        check_val("seq2_addr", IMemAddress, 64'hc);

        // Backpressure into HOLD, then simultaneous pop and push while full
        apply_reset();
        InstrReady = 1'b0;
        tick(20);
        check_head("bp_hold", 64'h0, 32'h910003E1);
        check_val("bp_hold_addr", IMemAddress, 64'h8);
        InstrReady = 1'b1;
        tick(1);
        check_head("bp_r1", 64'h4, 32'h910007E2);
        check_val("bp_r1_addr", IMemAddress, 64'hc);
        tick(1);
        check_head("bp_r2", 64'h8, 32'h910003E3);
        tick(1);
        check_val("bp_r3_valid", 64'(InstrValid), 64'd0);
        tick(1);
        check_head("bp_r4", 64'hc, 32'h8B020021);

        // Redirect with two words buffered; low address bits are dropped
        apply_reset();
        InstrReady = 1'b0;
        tick(6);
        check_head("rd_pre", 64'h0, 32'h910003E1);
        Redirect   = 1'b1;
        RedirectPC = 64'h00e;
        tick(1);
        Redirect   = 1'b0;
        check_empty("rd_flush");
        check_val("rd_addr", IMemAddress, 64'hc);
        InstrReady = 1'b1;
        tick(2);
        check_val("rd_wait_valid", 64'(InstrValid), 64'd0);
        tick(1);
        check_head("rd_new", 64'hc, 32'h8B020021);

        // Redirect on the very edge that would have pushed
        apply_reset();
        InstrReady = 1'b0;
        tick(2);
        Redirect   = 1'b1;
        RedirectPC = 64'h40;
        tick(1);
        Redirect   = 1'b0;
        check_empty("rdp_flush");
        check_val("rdp_addr", IMemAddress, 64'h40);
        tick(2);
        check_val("rdp_wait_valid", 64'(InstrValid), 64'd0);
        tick(1);
        check_head("rdp_new", 64'h40, 32'hA5A50040);

        // Asynchronous reset while holding a full buffer
        apply_reset();
        InstrReady = 1'b0;
        tick(12);
        check_head("hr_pre", 64'h0, 32'h910003E1);
        check_val("hr_pre_addr", IMemAddress, 64'h8);
        Reset = 1'b1;
        #1;
        check_empty("hr_async");
        check_val("hr_async_addr", IMemAddress, 64'h0);
        InstrReady = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(2);
        check_val("hr_wait_valid", 64'(InstrValid), 64'd0);
        tick(1);
        check_head("hr_refetch", 64'h0, 32'h910003E1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
